if_fetch_ctrl: RTL
==================

# if_fetch_ctrl

Fetch controller for the 5-stage ARM pipeline: owns the program counter, sequences requests to a variable-latency instruction memory over a req/ack handshake, and loads the IF/ID pipeline register. It resolves branch redirects and hazard freezes against in-flight fetches, so no instruction is lost, duplicated or fetched from a stale address. It sits between the hazard/branch logic (EXE stage) and the ID stage.

## Interface

- RESET_PC, 32'h0000_0000: PC value loaded on reset
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- freeze  in  1  hazard stall; hold the IF/ID contents and stop advancing
- branch_taken  in  1  redirect request from EXE; priority over freeze
- branch_addr  in  32  redirect target; bits [1:0] forced to 0
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, word aligned
- imem_ack  in  1  memory accepts the request; imem_rdata valid in the same cycle
- imem_rdata  in  32  instruction word
- if_valid  out  1  IF/ID entry holds a real instruction
- if_pc  out  32  address of the fetched instruction + 4
- if_instr  out  32  fetched instruction

## Operation

- States: IDLE, REQ, HOLD, DISCARD.
- Reset (rst low): pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0, hold buffer cleared. Takes effect immediately and may abort any state, including an outstanding request.
- IDLE: imem_req=0. Next state is REQ unconditionally, after one cycle.
- REQ: imem_req=1, imem_addr=pc.
  - ack, no branch, no freeze: IF/ID <= {1, pc+4, rdata}; pc <= pc+4; stay in REQ.
  - ack, no branch, freeze: rdata and pc+4 go to the hold buffer; pc <= pc+4; go to HOLD; IF/ID unchanged.
  - ack and branch in the same cycle: drop rdata; pc <= branch_addr; if_valid <= 0; stay in REQ.
  - no ack, branch: pc <= branch_addr; if_valid <= 0; go to DISCARD.
  - no ack, no branch: if_valid <= 0 unless freeze is high. Under freeze, IF/ID holds.
- HOLD: imem_req=0.
  - Freeze low: IF/ID <= hold buffer; go to REQ.
  - Branch: discard the buffer; pc <= branch_addr; if_valid <= 0; go to REQ.
- DISCARD: imem_req=1; imem_addr stays at the abandoned address. On ack, drop rdata and go to REQ. if_valid=0 throughout.
  - A further branch while in DISCARD overwrites pc.
- Handshake rule: while imem_req=1 and no ack, imem_addr must not change. It changes only on the cycle after an ack. A request is never withdrawn before its ack.
- Branch priority: branch_taken beats freeze in every state. Any branch clears if_valid on the next edge.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0). branch_addr[1:0] is ignored.

## Timing

- Zero-wait memory (ack tied high): edge 1 after rst release goes IDLE to REQ. Edge 2 gives if_valid=1, if_pc=RESET_PC+4. One instruction per cycle after that.
- N-cycle memory latency gives N-1 bubbles (if_valid=0) per instruction.
- Branch to first target instruction in IF/ID: 2 edges with zero-wait memory. When the redirect lands in DISCARD, add the remaining latency of the abandoned fetch.
- Freeze release from HOLD: the buffered instruction appears on the next edge, and the fetch of pc starts in that same cycle.
- All outputs are registered except imem_req and imem_addr. Those two are decoded from state and pc only, never combinationally from inputs.

## Structure

- Package if_fetch_pkg holds:
  - the state enum (IDLE, REQ, HOLD, DISCARD)
  - INSTR_W=32 and ADDR_W=32
  - the default RESET_PC
- One sub-module, if_id_reg: the IF/ID register with load, hold and clear controls, plus the one-entry hold buffer. The FSM, pc and handshake logic stay in if_fetch_ctrl.

## Test plan

- Reset release, ack tied high, memory returns words W0..W3 -> if_valid=1 from edge 2; if_pc = 4, 8, 12, 16 with if_instr W0..W3 in order.
- Ack delayed 3 cycles per request -> imem_addr stable while waiting; 2 bubbles between instructions; no word repeated or skipped.
- branch_taken with branch_addr=32'h40 while a request to 8 awaits ack -> DISCARD; data for 8 dropped after its ack; next request to 0x40; if_valid=0 until W(0x40) arrives with if_pc=0x44.
- Freeze raised 3 cycles during ack of address 12 -> IF/ID holds the previous entry; after release, if_instr=W(12), if_pc=16, then fetch of 16 continues.
- branch_taken and freeze together in HOLD with branch_addr=32'h103 -> buffer dropped; next request to 0x100.
- pc=32'hFFFF_FFFC acked -> next imem_addr=0. rst pulsed low mid-request -> all outputs return to reset values immediately and restart from RESET_PC.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM states, datapath widths and the reset PC.
package if_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] DEF_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DISCARD
    } state_t;

    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(4);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register plus a one-entry buffer for a word
// that arrives while the pipeline is frozen.
module if_id_reg
    import if_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic               buf_wr,
    input  logic               buf_pop,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic [INSTR_W-1:0] instr_in,
    output logic               valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr
);

    logic [ADDR_W-1:0]  buf_pc;
    logic [INSTR_W-1:0] buf_instr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid     <= 1'b0;
            pc        <= '0;
            instr     <= '0;
            buf_pc    <= '0;
            buf_instr <= '0;
        end else begin
            if (buf_wr) begin
                buf_pc    <= pc_in;
                buf_instr <= instr_in;
            end
            // clear wins so a redirect never lets a stale word through
            if (clear) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
                pc    <= pc_in;
                instr <= instr_in;
            end else if (buf_pop) begin
                valid <= 1'b1;
                pc    <= buf_pc;
                instr <= buf_instr;
            end
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch controller: owns the PC, runs the imem req/ack handshake
// and resolves branches and freezes against in-flight fetches.
module if_fetch_ctrl
    import if_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr
);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  disc_q, disc_d;
    logic [ADDR_W-1:0]  tgt;
    logic [ADDR_W-1:0]  pc_next;
    logic               load, clear, buf_wr, buf_pop;

    assign tgt     = branch_addr & 32'hFFFF_FFFC;
    assign pc_next = pc_inc(pc_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            disc_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            disc_q  <= disc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        disc_d  = disc_q;
        load    = 1'b0;
        clear   = 1'b0;
        buf_wr  = 1'b0;
        buf_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                if (branch_taken) begin
                    pc_d  = tgt;
                    clear = 1'b1;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    if (branch_taken) begin
                        pc_d  = tgt;
                        clear = 1'b1;
                    end else if (freeze) begin
                        buf_wr  = 1'b1;
                        pc_d    = pc_next;
                        state_d = HOLD;
                    end else begin
                        load = 1'b1;
                        pc_d = pc_next;
                    end
                end else if (branch_taken) begin
                    // request cannot be withdrawn; remember its address
                    disc_d  = pc_q;
                    pc_d    = tgt;
                    clear   = 1'b1;
                    state_d = DISCARD;
                end else if (!freeze) begin
                    clear = 1'b1;
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_d    = tgt;
                    clear   = 1'b1;
                    state_d = REQ;
                end else if (!freeze) begin
                    buf_pop = 1'b1;
                    state_d = REQ;
                end
            end
            DISCARD: begin
                clear = 1'b1;
                if (branch_taken) begin
                    pc_d = tgt;
                end
                if (imem_ack) begin
                    state_d = REQ;
                end
            end
        endcase
    end

    assign imem_req  = (state_q == REQ) || (state_q == DISCARD);
    assign imem_addr = (state_q == DISCARD) ? disc_q : pc_q;

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .clear    (clear),
        .buf_wr   (buf_wr),
        .buf_pop  (buf_pop),
        .pc_in    (pc_next),
        .instr_in (imem_rdata),
        .valid    (if_valid),
        .pc       (if_pc),
        .instr    (if_instr)
    );

endmodule
